// File: rtl/dff_pipe_if.sv
// rtl/dff_pipe_if.sv - handshake/data bundle for the dff_pipe delay line
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [TW-1:0]    tap_sel;
  logic [WIDTH-1:0] tap_q;
  logic             tap_valid;
  logic [OW-1:0]    occupancy;

  // Driver side: feeds data and selects the tap.
  modport master (
    output en, flush, d, d_valid, tap_sel,
    input  q, q_valid, tap_q, tap_valid, occupancy
  );

  // Pipeline side.
  modport slave (
    input  en, flush, d, d_valid, tap_sel,
    output q, q_valid, tap_q, tap_valid, occupancy
  );
endinterface

// File: rtl/dff_pipe.sv
// rtl/dff_pipe.sv - DEPTH-stage valid-tagged register pipeline with stall, flush, tap and occupancy; assertions under DFF_PIPE_SVA_EN
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic       clk,
  input logic       rst,
  dff_pipe_if.slave bus
);
  localparam int TW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [OW-1:0]    occ_r;
  logic [OW-1:0]    occ_nxt;

  // Occupancy after a shift: one tag enters at stage 0, one leaves from the last stage.
  always_comb begin
    occ_nxt = occ_r + OW'(bus.d_valid) - OW'(vld_r[DEPTH-1]);
  end

  // Data stages: shift on enable; flush does not gate data, only the tags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_r[i] <= RST_VAL;
    end else if (bus.en) begin
      data_r[0] <= bus.d;
      for (int i = DEPTH - 1; i > 0; i--) data_r[i] <= data_r[i-1];
    end
  end

  // Valid tags and occupancy: flush wins over enable and clears everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= '0;
      occ_r <= '0;
    end else if (bus.flush) begin
      vld_r <= '0;
      occ_r <= '0;
    end else if (bus.en) begin
      vld_r[0] <= bus.d_valid;
      for (int i = DEPTH - 1; i > 0; i--) vld_r[i] <= vld_r[i-1];
      occ_r <= occ_nxt;
    end
  end

  // Tap mux: out-of-range indices read as an empty reset-valued stage.
  always_comb begin
    bus.tap_q     = RST_VAL;
    bus.tap_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.tap_sel == TW'(i)) begin
        bus.tap_q     = data_r[i];
        bus.tap_valid = vld_r[i];
      end
    end
  end

  assign bus.q         = data_r[DEPTH-1];
  assign bus.q_valid   = vld_r[DEPTH-1];
  assign bus.occupancy = occ_r;

`ifdef DFF_PIPE_SVA_EN
  a_hold: assert property (@(posedge clk) disable iff (rst)
    !bus.en && !bus.flush |=> bus.q == $past(bus.q) && bus.occupancy == $past(bus.occupancy))
    else $error("a_hold");

  a_shift: assert property (@(posedge clk) disable iff (rst)
    bus.en && !bus.flush |=> data_r[0] == $past(bus.d))
    else $error("a_shift");

  a_flush: assert property (@(posedge clk) disable iff (rst)
    bus.flush |=> bus.occupancy == '0 && !bus.q_valid)
    else $error("a_flush");

  a_occ: assert property (@(posedge clk) disable iff (rst)
    int'(occ_r) == $countones(vld_r))
    else $error("a_occ");

  // Reset is asynchronous, so sample its effect mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      a_rst: assert (bus.q == RST_VAL && occ_r == '0) else $error("a_rst");
    end
  end
`else
`endif
endmodule

// File: tb/tb_dff_pipe.sv
// tb/tb_dff_pipe.sv - directed-vector bench for dff_pipe
module tb_dff_pipe;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  dff_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();
  dff_pipe_if #(.WIDTH(8), .DEPTH(3)) bus3 ();

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h5A)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  assign bus3.en      = bus.en;
  assign bus3.flush   = bus.flush;
  assign bus3.d       = bus.d;
  assign bus3.d_valid = bus.d_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] dv, input logic vv);
    bus.d       = dv;
    bus.d_valid = vv;
    step();
  endtask

  logic [7:0] bub_d [4];
  logic       bub_v [4];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.flush = 1'b0;
    bus.d = 8'hA5;
    bus.d_valid = 1'b1;
    bus.tap_sel = 2'd0;
    bus3.tap_sel = 2'd3;

    // Reset held across clocks with live inputs
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_q", bus.q, 8'h00);
      check_eq("rst_qv", bus.q_valid, 0);
      check_eq("rst_occ", bus.occupancy, 0);
      check_eq("rst_tapv", bus.tap_valid, 0);
    end
    check_eq("rst_q_d3", bus3.q, 8'h5A);
    check_eq("oor_tapq_d3", bus3.tap_q, 8'h5A);
    check_eq("oor_tapv_d3", bus3.tap_valid, 0);

    // Latency: DEPTH edges including the capture edge
    rst = 1'b0;
    drive(8'h11, 1'b1);
    drive(8'h22, 1'b1);
    drive(8'h33, 1'b1);
    check_eq("lat3_qv", bus.q_valid, 0);
    check_eq("lat3_occ", bus.occupancy, 3);
    check_eq("lat3_q_d3", bus3.q, 8'h11);
    check_eq("lat3_qv_d3", bus3.q_valid, 1);
    drive(8'h44, 1'b1);
    check_eq("lat4_q", bus.q, 8'h11);
    check_eq("lat4_qv", bus.q_valid, 1);
    check_eq("lat4_occ", bus.occupancy, 4);
    check_eq("full_occ_d3", bus3.occupancy, 3);

    // Stall while inputs toggle
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'hF0 ^ 8'(i * 8'h33), 1'(i & 1));
      check_eq("hold_q", bus.q, 8'h11);
      check_eq("hold_occ", bus.occupancy, 4);
    end
    bus.en = 1'b1;
    drive(8'h55, 1'b1);
    check_eq("resume_q", bus.q, 8'h22);
    check_eq("resume_occ", bus.occupancy, 4);

    // Flush together with enable and a valid input
    bus.flush = 1'b1;
    drive(8'h66, 1'b1);
    bus.flush = 1'b0;
    bus.en = 1'b0;
    check_eq("flush_occ", bus.occupancy, 0);
    check_eq("flush_qv", bus.q_valid, 0);
    for (int s = 0; s < 4; s++) begin
      bus.tap_sel = 2'(s);
      #1;
      check_eq("flush_tapv", bus.tap_valid, 0);
    end

    // Tap and bubble pattern
    bus.en = 1'b1;
    bub_d[0] = 8'd1; bub_v[0] = 1'b1;
    bub_d[1] = 8'd2; bub_v[1] = 1'b0;
    bub_d[2] = 8'd3; bub_v[2] = 1'b1;
    bub_d[3] = 8'd4; bub_v[3] = 1'b0;
    for (int i = 0; i < 4; i++) drive(bub_d[i], bub_v[i]);
    for (int s = 0; s < 4; s++) begin
      bus.tap_sel = 2'(s);
      #1;
      check_eq("bub_tapq", bus.tap_q, 32'(4 - s));
      check_eq("bub_tapv", bus.tap_valid, 32'(s & 1));
    end
    check_eq("bub_occ", bus.occupancy, 2);
    check_eq("bub_q", bus.q, 8'd1);

    // Bring occupancy to 3, then reset asynchronously mid-cycle
    drive(8'd5, 1'b1);
    drive(8'd6, 1'b1);
    check_eq("pre_arst_occ", bus.occupancy, 3);
    check_eq("pre_arst_q", bus.q, 8'd3);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_q", bus.q, 8'h00);
    check_eq("arst_occ", bus.occupancy, 0);
    check_eq("arst_qv", bus.q_valid, 0);
    check_eq("arst_q_d3", bus3.q, 8'h5A);
    check_eq("arst_occ_d3", bus3.occupancy, 0);
    step();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
- Parametrised D-flop pipeline: a chain of DEPTH registered stages, each WIDTH bits wide.
- Each stage carries a valid tag.
- Features: global stall (enable), synchronous flush, a selectable tap output and a live occupancy count.
- Generalises the single D flip-flop into a reusable delay/retiming line for datapaths in the same design.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of register stages; sets latency (>=1)
- RST_VAL, 0, value loaded into every data stage on reset (WIDTH bits)

Ports:
- clk  input  1  clock; all state changes on posedge
- rst  input  1  asynchronous, active-high reset
- en  input  1  shift enable; 0 = hold all stages
- flush  input  1  synchronous clear of all valid tags
- d  input  WIDTH  data into stage 0
- d_valid  input  1  valid tag for d
- q  output  WIDTH  data of stage DEPTH-1
- q_valid  output  1  valid tag of stage DEPTH-1
- tap_sel  input  TW  stage index for tap; TW = max(1,$clog2(DEPTH))
- tap_q  output  WIDTH  data of stage tap_sel
- tap_valid  output  1  valid tag of stage tap_sel
- occupancy  output  OW  number of valid stages; OW = $clog2(DEPTH+1)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset, asynchronous, takes effect immediately without a clock edge:
  - all data stages = RST_VAL;
  - all valid tags = 0;
  - occupancy = 0.
  - So q = RST_VAL, q_valid = 0, tap_valid = 0.
- Reset release: first active edge is the first posedge with rst low.
- Reset mid-operation: all in-flight data is lost; there is no partial retention.
- Priority per posedge: rst > flush > en.
- Shift (en=1, flush=0):
  - stage[0] <= {d, d_valid};
  - stage[i] <= stage[i-1] for i = 1..DEPTH-1.
- Hold (en=0, flush=0): every stage, valid tag and occupancy keeps its value; d and d_valid are ignored.
- Flush (flush=1):
  - all valid tags <= 0 and occupancy <= 0, regardless of en;
  - incoming d_valid is discarded;
  - data stages shift if en=1 and hold if en=0, and their data is don't-care afterwards.
- Latency: with en held 1, d sampled at edge N appears on q after edge N+DEPTH-1, i.e. DEPTH posedges including the capture edge.
- DEPTH=1: q is a plain enabled D flop with valid tag; tap_sel is 1 bit, and only value 0 is in range.
- Tap output:
  - combinational select of stage tap_sel;
  - tap_sel >= DEPTH returns tap_q = RST_VAL, tap_valid = 0.
- Occupancy:
  - registered, and always equals the popcount of the valid tags after each edge;
  - on a shift the count changes by +1 (valid in, invalid out), -1 (invalid in, valid out) or 0;
  - the range is 0..DEPTH and it never wraps.
- No combinational path from d to q when DEPTH>=1. The only combinational paths are tap_sel to tap_q and tap_sel to tap_valid.

Optional Feature:
- Macro: DFF_PIPE_SVA_EN
- Defined: the module compiles concurrent assertions clocked on posedge clk with disable iff (rst):
  - a_hold: !en && !flush |=> q == $past(q) && occupancy == $past(occupancy)
  - a_shift: en && !flush |=> stage[0] data == $past(d)
  - a_flush: flush |=> occupancy == 0 && !q_valid
  - a_occ: occupancy == $countones(valid tags) at every edge
  - a_rst: immediate check that q == RST_VAL && occupancy == 0 while rst is high
  - Failures report via $error naming the assertion.
- Undefined: no assertion code is compiled, and RTL behaviour is identical.

Test Plan:
- Reset: rst=1 with d=8'hA5, d_valid=1, en=1 for 3 clocks -> q=8'h00, q_valid=0, occupancy=0 throughout.
- Latency: release rst, en=1, drive d=8'h11,8'h22,8'h33,8'h44 with d_valid=1 on consecutive edges (DEPTH=4) -> q=8'h11 with q_valid=1 after the 4th edge; occupancy=4.
- Stall: from the full state, en=0 for 5 clocks while d toggles -> q stays 8'h11 and occupancy stays 4; re-assert en -> q steps to 8'h22 on the next edge.
- Flush: with occupancy=4, assert flush and en together with d_valid=1 for one clock -> occupancy=0, q_valid=0, tap_valid=0 for all tap_sel on the next cycle.
- Tap and bubble: drive valid, invalid, valid, invalid pattern with d=1,2,3,4 -> after 4 edges tap_sel=0..3 shows d=4,3,2,1 with tap_valid=0,1,0,1 and occupancy=2.
- Async reset mid-stream: assert rst between clock edges while occupancy=3 -> q=RST_VAL and occupancy=0 immediately, before the next posedge.
